// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: register map, STATUS bits, FSM states.
package dmem_responder_pkg;

    localparam logic [15:0] ADDR_TIMER  = 16'hFF00;
    localparam logic [15:0] ADDR_GPIO   = 16'hFF01;
    localparam logic [15:0] ADDR_STATUS = 16'hFF02;

    localparam int STATUS_INIT_BIT = 0;
    localparam int STATUS_OVF_BIT  = 1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Processor data-port bundle between a core (master) and dmem_responder (slave).
// Single-cycle load/store, no handshake: the slave accepts an access every cycle.
interface dmem_responder_if;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        init_done;
    logic [31:0] gpio_out;

    modport master (
        output mem_addr, mem_wdata, mem_wr,
        input  mem_rdata, init_done, gpio_out
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wr,
        output mem_rdata, init_done, gpio_out
    );
endinterface

// File: rtl/dmem_responder_timer.sv
// Free-running 32-bit timer with loadable value and sticky wrap flag (present only with DMEM_RESPONDER_TIMER_EN).
// Updates every cycle; no backpressure.
module dmem_responder_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_timer_i,
    input  logic        clr_ovf_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] timer_o,
    output logic        ovf_o
);
    logic [31:0] timer_q, timer_d;
    logic        ovf_q, ovf_d;
    logic        wrap;

    // A load replaces the increment, so it can never wrap; a wrap beats a clear.
    always_comb begin
        wrap    = !wr_timer_i && (timer_q == 32'hFFFF_FFFF);
        timer_d = wr_timer_i ? wdata_i : timer_q + 32'd1;
        ovf_d   = wrap | (ovf_q & ~clr_ovf_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end

    assign timer_o = timer_q;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/dmem_responder.sv
// Processor data RAM plus TIMER/GPIO/STATUS registers; RAM is zeroed after reset (optional timer: DMEM_RESPONDER_TIMER_EN).
// Loads return one cycle later, read-first on stores; no backpressure, every cycle accepted.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] IDX_LAST = '1;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    state_t                  state_q;
    logic [DEPTH_LOG2-1:0]   clr_idx_q;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             gpio_q;
    logic [31:0]             mem [WORDS];

    logic                    sel_ram, sel_timer, sel_gpio, sel_status;
    logic [DEPTH_LOG2-1:0]   ram_idx;
    logic                    ram_we;
    logic [DEPTH_LOG2-1:0]   ram_waddr;
    logic [31:0]             ram_wdat;
    logic [31:0]             timer_val;
    logic                    ovf;

    assign sel_ram    = !bus.mem_addr[15];
    assign sel_timer  = (bus.mem_addr == ADDR_TIMER);
    assign sel_gpio   = (bus.mem_addr == ADDR_GPIO);
    assign sel_status = (bus.mem_addr == ADDR_STATUS);
    assign ram_idx    = bus.mem_addr[DEPTH_LOG2-1:0];

`ifdef DMEM_RESPONDER_TIMER_EN
    dmem_responder_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_timer_i (bus.mem_wr && sel_timer),
        .clr_ovf_i  (bus.mem_wr && sel_status && bus.mem_wdata[STATUS_OVF_BIT]),
        .wdata_i    (bus.mem_wdata),
        .timer_o    (timer_val),
        .ovf_o      (ovf)
    );
`else
    assign timer_val = '0;
    assign ovf       = 1'b0;
`endif

    // The single RAM write port belongs to the clear sequence until RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ram_idx;
        ram_wdat  = bus.mem_wdata;
        if (state_q == INIT) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx_q;
            ram_wdat  = '0;
        end else if (bus.mem_wr && sel_ram) begin
            ram_we    = 1'b1;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (sel_ram) begin
            rdata_d = (state_q == RUN) ? mem[ram_idx] : '0;
        end else if (sel_timer) begin
            rdata_d = timer_val;
        end else if (sel_gpio) begin
            rdata_d = gpio_q;
        end else if (sel_status) begin
            rdata_d[STATUS_INIT_BIT] = (state_q == RUN);
            rdata_d[STATUS_OVF_BIT]  = ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INIT;
            clr_idx_q <= '0;
            rdata_q   <= '0;
            gpio_q    <= '0;
        end else begin
            rdata_q <= rdata_d;
            if (bus.mem_wr && sel_gpio) begin
                gpio_q <= bus.mem_wdata;
            end
            if (state_q == INIT) begin
                if (clr_idx_q == IDX_LAST) begin
                    state_q <= RUN;
                end else begin
                    clr_idx_q <= clr_idx_q + IDX_ONE;
                end
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.init_done = (state_q == RUN);
    assign bus.gpio_out  = gpio_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with DEPTH_LOG2=4: directed table, corner sequences, random vs reference model.
module tb_dmem_responder;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_LOG2(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain memory image and register values, INIT tracked as edges since reset release.
    bit [31:0] ram_m [16];
    bit [31:0] gpio_m;
    bit [31:0] timer_m;
    bit        ovf_m;
    int        edges_m;
    bit [31:0] exp_rdata_m;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [31:0] exp_rdata;
        logic [31:0] exp_gpio;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ram_m[i] = '0;
        gpio_m      = '0;
        timer_m     = '0;
        ovf_m       = 1'b0;
        edges_m     = 0;
        exp_rdata_m = '0;
    endtask

    task automatic model_edge(input logic [15:0] a, input logic [31:0] d, input logic w);
        bit        in_init;
        bit [31:0] r;
        bit        wrap;
        in_init = (edges_m < 16);
        r = '0;
        if (a[15] == 1'b0)        r = in_init ? 32'h0 : ram_m[a[3:0]];
        else if (a == 16'hFF00) begin
`ifdef DMEM_RESPONDER_TIMER_EN
            r = timer_m;
`else
            r = '0;
`endif
        end
        else if (a == 16'hFF01)   r = gpio_m;
        else if (a == 16'hFF02)   r = {30'b0, ovf_m, !in_init};

        if (w && a[15] == 1'b0 && !in_init) ram_m[a[3:0]] = d;
        if (w && a == 16'hFF01) gpio_m = d;
`ifdef DMEM_RESPONDER_TIMER_EN
        wrap = !(w && a == 16'hFF00) && (timer_m == 32'hFFFF_FFFF);
        if (w && a == 16'hFF00) timer_m = d;
        else                    timer_m = timer_m + 32'd1;
        if (wrap)                           ovf_m = 1'b1;
        else if (w && a == 16'hFF02 && d[1]) ovf_m = 1'b0;
`else
        wrap = 1'b0;
        if (wrap) ovf_m = 1'b1;
`endif
        exp_rdata_m = r;
        edges_m++;
    endtask

    // Called at a falling edge: drive, let one rising edge sample, then check at the next falling edge.
    task automatic step(input logic [15:0] a, input logic [31:0] d, input logic w);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_wr    = w;
        @(posedge clk);
        model_edge(a, d, w);
        @(negedge clk);
        check($sformatf("rdata@%h", a), bus.mem_rdata, exp_rdata_m);
        check("init_done", {31'b0, bus.init_done}, {31'b0, (edges_m >= 16)});
        check("gpio_out", bus.gpio_out, gpio_m);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset rdata", bus.mem_rdata, 32'h0);
        check("reset gpio", bus.gpio_out, 32'h0);
        check("reset init_done", {31'b0, bus.init_done}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wr    = 1'b0;
        model_reset();

        vecs[0]  = '{16'h0005, 32'h0,         1'b0, 32'h0,         32'h0};
        vecs[1]  = '{16'h0005, 32'hDEADBEEF,  1'b1, 32'h0,         32'h0};
        vecs[2]  = '{16'h0005, 32'h0,         1'b0, 32'hDEADBEEF,  32'h0};
        vecs[3]  = '{16'h0003, 32'hAAAAAAAA,  1'b1, 32'h0,         32'h0};
        vecs[4]  = '{16'h0003, 32'h12345678,  1'b1, 32'hAAAAAAAA,  32'h0};
        vecs[5]  = '{16'h0003, 32'h0,         1'b0, 32'h12345678,  32'h0};
        vecs[6]  = '{16'h0013, 32'h0,         1'b0, 32'h12345678,  32'h0};
        vecs[7]  = '{16'hFF01, 32'h000000A5,  1'b1, 32'h0,         32'hA5};
        vecs[8]  = '{16'hFF01, 32'h0,         1'b0, 32'hA5,        32'hA5};
        vecs[9]  = '{16'hFF02, 32'h0,         1'b0, 32'h1,         32'hA5};
        vecs[10] = '{16'h9000, 32'h7,         1'b1, 32'h0,         32'hA5};
        vecs[11] = '{16'h9000, 32'h0,         1'b0, 32'h0,         32'hA5};
        vecs[12] = '{16'h0000, 32'h0,         1'b0, 32'h0,         32'hA5};
        vecs[13] = '{16'hFF02, 32'hFFFFFFFF,  1'b1, 32'h1,         32'hA5};
        vecs[14] = '{16'hFF02, 32'h0,         1'b0, 32'h1,         32'hA5};

        @(negedge clk);
        do_reset();

        // INIT: 16 cycles of init_done=0, a dropped store, then all words read back as 0.
        for (int i = 0; i < 16; i++) begin
            if (i == 3) step(16'h0005, 32'hDEADBEEF, 1'b1);
            else        step(16'(i), 32'h0, 1'b0);
        end
        check("init_done after 16", {31'b0, bus.init_done}, 32'h1);
        for (int i = 0; i < 16; i++) step(16'(i), 32'h0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].addr, vecs[i].wdata, vecs[i].wr);
            check($sformatf("vec%0d rdata", i), bus.mem_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d gpio", i), bus.gpio_out, vecs[i].exp_gpio);
        end

`ifdef DMEM_RESPONDER_TIMER_EN
        step(16'hFF00, 32'hFFFFFFFE, 1'b1);
        step(16'hFF02, 32'h0, 1'b0);
        step(16'hFF02, 32'h0, 1'b0);
        step(16'hFF02, 32'h0, 1'b0);
        check("status after wrap", bus.mem_rdata, 32'h3);
        step(16'hFF02, 32'h2, 1'b1);
        step(16'hFF02, 32'h0, 1'b0);
        check("status after clear", bus.mem_rdata, 32'h1);
        step(16'hFF00, 32'hFFFFFFFF, 1'b1);
        step(16'hFF02, 32'h2, 1'b1);
        step(16'hFF02, 32'h0, 1'b0);
        check("wrap beats clear", bus.mem_rdata, 32'h3);
        step(16'hFF00, 32'h5, 1'b1);
        step(16'hFF00, 32'h0, 1'b0);
        check("timer load", bus.mem_rdata, 32'h5);
`else
        step(16'hFF00, 32'h5, 1'b1);
        step(16'hFF00, 32'h0, 1'b0);
        check("timer absent", bus.mem_rdata, 32'h0);
        step(16'hFF02, 32'h0, 1'b0);
        check("status no ovf", bus.mem_rdata, 32'h1);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            int          kind;
            kind = $urandom_range(0, 6);
            case (kind)
                0, 1, 2: a = 16'($urandom_range(0, 16'h7FFF));
                3:       a = 16'hFF00;
                4:       a = 16'hFF01;
                5:       a = 16'hFF02;
                default: a = 16'($urandom_range(16'h8000, 16'hFEFF));
            endcase
            step(a, $urandom(), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of INIT must restart the clear from word 0.
        for (int i = 0; i < 16; i++) step(16'(i), 32'hC0DE0000 | i, 1'b1);
        do_reset();
        for (int i = 0; i < 7; i++) step(16'hFF01, 32'hA5, 1'(i == 2));
        check("gpio in INIT", bus.gpio_out, 32'hA5);
        do_reset();
        for (int i = 0; i < 16; i++) step(16'(i), 32'h0, 1'b0);
        check("rerun init_done", {31'b0, bus.init_done}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            step(16'(i), 32'h0, 1'b0);
            check($sformatf("cleared word %0d", i), bus.mem_rdata, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
